// File: rtl/mlx90640_pkg.sv
// rtl/mlx90640_pkg.sv - shared MLX90640 geometry, merge FSM states and chess-mask helper
package mlx90640_pkg;

    localparam int MLX_COLS   = 32;
    localparam int MLX_ROWS   = 24;
    localparam int MLX_PIXELS = MLX_COLS * MLX_ROWS;
    localparam int MLX_AUX    = 64;
    localparam int MLX_WORDS  = MLX_PIXELS + MLX_AUX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } merge_state_t;

    // Subpage 0 owns pixels whose row+col is even; subpage 1 owns the rest.
    function automatic logic mlx_chess_bit(input int k, input logic sp);
        int row;
        int col;
        logic even;
        row  = k / MLX_COLS;
        col  = k % MLX_COLS;
        even = (((row + col) & 1) == 0);
        return sp ? ~even : even;
    endfunction

endpackage

// File: rtl/mlx90640_subpage_merge_if.sv
// rtl/mlx90640_subpage_merge_if.sv - sensor word stream in, frame-buffer write port and status out
interface mlx90640_subpage_merge_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32*24+64
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    logic             start;
    logic             subpage;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_wr_en;
    logic [ADDRW-1:0] m_wr_addr;
    logic [WIDTH-1:0] m_wr_data;
    logic             busy;
    logic             done;
    logic [CW-1:0]    wr_count;

    modport master (
        output start, subpage, s_valid, s_data,
        input  s_ready, m_wr_en, m_wr_addr, m_wr_data, busy, done, wr_count
    );

    modport slave (
        input  start, subpage, s_valid, s_data,
        output s_ready, m_wr_en, m_wr_addr, m_wr_data, busy, done, wr_count
    );

endinterface

// File: rtl/mlx90640_subpages_rom_sync.sv
// rtl/mlx90640_subpages_rom_sync.sv - registered-output chess-pattern mask ROM for both subpages
module mlx90640_subpages_rom_sync
    import mlx90640_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = MLX_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [WIDTH-1:0]         data_pg0,
    output logic [WIDTH-1:0]         data_pg1
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SIZE = 1 << AW;

    // Table is padded to a power of two so the one-past-last lookahead address reads 0.
    function automatic logic [SIZE-1:0] build_mask(input logic sp);
        logic [SIZE-1:0] m;
        m = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < MLX_PIXELS) begin
                m[k] = mlx_chess_bit(k, sp);
            end
        end
        return m;
    endfunction

    localparam logic [SIZE-1:0] MASK_PG0 = build_mask(1'b0);
    localparam logic [SIZE-1:0] MASK_PG1 = build_mask(1'b1);

    logic [WIDTH-1:0] data_pg0_d, data_pg0_q;
    logic [WIDTH-1:0] data_pg1_d, data_pg1_q;

    always_comb begin
        data_pg0_d    = '0;
        data_pg1_d    = '0;
        data_pg0_d[0] = MASK_PG0[addr];
        data_pg1_d[0] = MASK_PG1[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_pg0_q <= '0;
            data_pg1_q <= '0;
        end else begin
            data_pg0_q <= data_pg0_d;
            data_pg1_q <= data_pg1_d;
        end
    end

    assign data_pg0 = data_pg0_q;
    assign data_pg1 = data_pg1_q;

endmodule

// File: rtl/mlx90640_subpage_merge.sv
// rtl/mlx90640_subpage_merge.sv - writes one subpage's pixels plus all aux words of a RAM dump to the frame buffer
module mlx90640_subpage_merge
    import mlx90640_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32*24+64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mlx90640_subpage_merge_if.slave   bus
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(DEPTH-1);
    localparam logic [ADDRW-1:0] AUX_BASE = ADDRW'(MLX_PIXELS);

    merge_state_t     state_d, state_q;
    logic             sp_d, sp_q;
    logic [ADDRW-1:0] idx_d, idx_q;
    logic [CW-1:0]    wr_count_d, wr_count_q;
    logic             m_wr_en_d, m_wr_en_q;
    logic [ADDRW-1:0] m_wr_addr_d, m_wr_addr_q;
    logic [WIDTH-1:0] m_wr_data_d, m_wr_data_q;

    logic [ADDRW-1:0] rom_addr;
    logic [0:0]       data_pg0;
    logic [0:0]       data_pg1;
    logic             accept;
    logic             sel;

    mlx90640_subpages_rom_sync #(
        .WIDTH (1),
        .DEPTH (MLX_WORDS)
    ) u_rom (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (rom_addr),
        .data_pg0 (data_pg0),
        .data_pg1 (data_pg1)
    );

    assign accept = (state_q == RUN) && bus.s_valid;
    assign sel    = sp_q ? data_pg1[0] : data_pg0[0];

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        idx_d       = idx_q;
        wr_count_d  = wr_count_q;
        m_wr_en_d   = 1'b0;
        m_wr_addr_d = m_wr_addr_q;
        m_wr_data_d = m_wr_data_q;
        rom_addr    = idx_q;
        case (state_q)
            IDLE: begin
                rom_addr = '0;
                if (bus.start) begin
                    sp_d       = bus.subpage;
                    idx_d      = '0;
                    wr_count_d = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                state_d = RUN;
            end
            RUN: begin
                // Look one word ahead on accept so the next mask bit lands without a bubble.
                if (accept) begin
                    rom_addr    = idx_q + 1'b1;
                    m_wr_addr_d = idx_q;
                    m_wr_data_d = bus.s_data;
                    m_wr_en_d   = sel || (idx_q >= AUX_BASE);
                    if (m_wr_en_d) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sp_q        <= 1'b0;
            idx_q       <= '0;
            wr_count_q  <= '0;
            m_wr_en_q   <= 1'b0;
            m_wr_addr_q <= '0;
            m_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            idx_q       <= idx_d;
            wr_count_q  <= wr_count_d;
            m_wr_en_q   <= m_wr_en_d;
            m_wr_addr_q <= m_wr_addr_d;
            m_wr_data_q <= m_wr_data_d;
        end
    end

    assign bus.s_ready   = (state_q == RUN);
    assign bus.busy      = (state_q == FETCH) || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.m_wr_en   = m_wr_en_q;
    assign bus.m_wr_addr = m_wr_addr_q;
    assign bus.m_wr_data = m_wr_data_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_mlx90640_subpage_merge.sv
// tb/tb_mlx90640_subpage_merge.sv - table-driven bench for mlx90640_subpage_merge
module tb_mlx90640_subpage_merge;

    typedef struct {
        bit sp;
        int gap;
        bit abuse;
        int exp_count;
        bit w0;
        bit w1;
        bit w32;
        bit w33;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mlx90640_subpage_merge_if #(.WIDTH(16), .DEPTH(832)) bus ();

    mlx90640_subpage_merge #(.WIDTH(16), .DEPTH(832)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int wlog_addr[$];
    int wlog_data[$];
    int ref0[$];
    int ref1[$];
    int done_cnt;
    bit done_ok;
    bit logging = 1'b0;
    bit pix0[768];
    bit pix1[768];
    vec_t tbl[6];

    always @(negedge clk) begin
        if (logging) begin
            if (bus.m_wr_en) begin
                wlog_addr.push_back(int'(bus.m_wr_addr));
                wlog_data.push_back(int'(bus.m_wr_data));
            end
            if (bus.done) begin
                done_cnt = done_cnt + 1;
                done_ok  = bus.m_wr_en && (bus.m_wr_addr == 10'd831);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit model_wr(input bit sp, input int a);
        int row;
        int col;
        if (a >= 768) return 1'b1;
        row = a / 32;
        col = a % 32;
        if ((row + col) % 2 == 0) return (sp == 1'b0);
        return (sp == 1'b1);
    endfunction

    task automatic run_dump(input vec_t v, input int r);
        int  idx;
        int  cyc;
        int  errs;
        int  derrs;
        bit  vnow;
        bit  wb[832];
        string p;
        p = $sformatf("r%0d", r);
        wlog_addr.delete();
        wlog_data.delete();
        done_cnt = 0;
        done_ok  = 1'b0;
        logging  = 1'b1;
        @(negedge clk);
        bus.subpage = v.sp;
        bus.start   = 1'b1;
        if (v.abuse) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'hDEAD;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({p, "_busy_after_start"}, int'(bus.busy), 1);
        check({p, "_ready_in_fetch"}, int'(bus.s_ready), 0);
        @(negedge clk);
        check({p, "_ready_two_cycles"}, int'(bus.s_ready), 1);
        idx = 0;
        cyc = 0;
        while (idx < 832 && cyc < 5000) begin
            vnow = (v.gap == 0) || ($urandom_range(99) >= v.gap);
            if (v.abuse && idx == 100) begin
                bus.subpage = ~v.sp;
                bus.start   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            bus.s_valid = vnow;
            bus.s_data  = 16'(idx);
            if (vnow && bus.s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        check({p, "_words_consumed"}, idx, 832);
        check({p, "_done_high"}, int'(bus.done), 1);
        check({p, "_done_with_last_write"}, int'(bus.m_wr_en && bus.m_wr_addr == 10'd831), 1);
        @(negedge clk);
        check({p, "_busy_low_after"}, int'(bus.busy), 0);
        check({p, "_done_one_cycle"}, int'(bus.done), 0);
        check({p, "_no_write_after"}, int'(bus.m_wr_en || bus.s_ready), 0);
        check({p, "_wr_count"}, int'(bus.wr_count), v.exp_count);
        logging = 1'b0;
        check({p, "_done_pulses"}, done_cnt, 1);
        check({p, "_done_ok"}, int'(done_ok), 1);
        check({p, "_write_count"}, wlog_addr.size(), v.exp_count);
        foreach (wb[a]) wb[a] = 1'b0;
        derrs = 0;
        foreach (wlog_addr[i]) begin
            if (wlog_addr[i] >= 0 && wlog_addr[i] < 832) wb[wlog_addr[i]] = 1'b1;
            if (wlog_data[i] != wlog_addr[i]) derrs++;
        end
        check({p, "_data_eq_addr_errs"}, derrs, 0);
        check({p, "_addr0"}, int'(wb[0]), int'(v.w0));
        check({p, "_addr1"}, int'(wb[1]), int'(v.w1));
        check({p, "_addr32"}, int'(wb[32]), int'(v.w32));
        check({p, "_addr33"}, int'(wb[33]), int'(v.w33));
        check({p, "_addr831"}, int'(wb[831]), 1);
        errs = 0;
        for (int a = 0; a < 832; a++) begin
            if (wb[a] != model_wr(v.sp, a)) begin
                if (errs == 0) $display("FAIL %s_mask: addr %0d written=%0d required=%0d", p, a, wb[a], model_wr(v.sp, a));
                errs++;
            end
        end
        check({p, "_mask_errs"}, errs, 0);
        if (v.gap == 0 && !v.abuse) begin
            if (v.sp) ref1 = wlog_addr;
            else      ref0 = wlog_addr;
            for (int a = 0; a < 768; a++) begin
                if (v.sp) pix1[a] = wb[a];
                else      pix0[a] = wb[a];
            end
        end else begin
            int expq[$];
            if (v.sp) expq = ref1;
            else      expq = ref0;
            errs = (expq.size() != wlog_addr.size()) ? 1 : 0;
            if (errs == 0) begin
                foreach (expq[i]) if (expq[i] != wlog_addr[i]) errs++;
            end
            check({p, "_seq_vs_back_to_back"}, errs, 0);
        end
    endtask

    initial begin
        int idx;
        int cyc;
        int wcnt;
        int cover_errs;

        tbl[0] = '{sp: 1'b0, gap: 0,  abuse: 1'b0, exp_count: 448, w0: 1'b1, w1: 1'b0, w32: 1'b0, w33: 1'b1};
        tbl[1] = '{sp: 1'b1, gap: 0,  abuse: 1'b0, exp_count: 448, w0: 1'b0, w1: 1'b1, w32: 1'b1, w33: 1'b0};
        tbl[2] = '{sp: 1'b0, gap: 50, abuse: 1'b0, exp_count: 448, w0: 1'b1, w1: 1'b0, w32: 1'b0, w33: 1'b1};
        tbl[3] = '{sp: 1'b1, gap: 50, abuse: 1'b0, exp_count: 448, w0: 1'b0, w1: 1'b1, w32: 1'b1, w33: 1'b0};
        tbl[4] = '{sp: 1'b0, gap: 0,  abuse: 1'b1, exp_count: 448, w0: 1'b1, w1: 1'b0, w32: 1'b0, w33: 1'b1};
        tbl[5] = '{sp: 1'b1, gap: 30, abuse: 1'b1, exp_count: 448, w0: 1'b0, w1: 1'b1, w32: 1'b1, w33: 1'b0};

        bus.start   = 1'b0;
        bus.subpage = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start   = 1'($urandom);
            bus.subpage = 1'($urandom);
            bus.s_valid = 1'($urandom);
            bus.s_data  = 16'($urandom);
        end
        @(negedge clk);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_m_wr_en", int'(bus.m_wr_en), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_m_wr_addr", int'(bus.m_wr_addr), 0);
        check("rst_m_wr_data", int'(bus.m_wr_data), 0);
        check("rst_wr_count", int'(bus.wr_count), 0);
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        rst_n       = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) run_dump(tbl[r], r);

        cover_errs = 0;
        for (int a = 0; a < 768; a++) if (int'(pix0[a]) + int'(pix1[a]) != 1) cover_errs++;
        check("union_covers_pixels_once", cover_errs, 0);

        @(negedge clk);
        bus.subpage = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        idx = 0;
        cyc = 0;
        while (idx < 400 && cyc < 2000) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 16'(idx);
            if (bus.s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        check("mid_rst_reached_word_400", idx, 400);
        check("mid_rst_count_before", int'(bus.wr_count), 200);
        #2;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_s_ready", int'(bus.s_ready), 0);
        check("mid_rst_m_wr_en", int'(bus.m_wr_en), 0);
        check("mid_rst_m_wr_addr", int'(bus.m_wr_addr), 0);
        check("mid_rst_m_wr_data", int'(bus.m_wr_data), 0);
        check("mid_rst_wr_count", int'(bus.wr_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.m_wr_en || bus.busy) wcnt++;
        end
        check("post_rst_quiet", wcnt, 0);
        run_dump(tbl[0], 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mlx90640_subpage_merge.md
# mlx90640_subpage_merge

Consumer of the MLX90640 subpage chess-pattern mask ROMs. Takes the raw 832-word RAM dump read from the sensor after a measurement, looks up each word's pixel in the mask for the active subpage, and writes only that subpage's pixels, plus all 64 auxiliary words, into the downstream frame buffer. Sits between the I2C frame reader and the frame-buffer write port.

## Interface
Parameters:
- `WIDTH`, 16: sensor word width.
- `DEPTH`, 32*24+64: words per dump, 768 pixels plus 64 aux.
- `ADDRW`, `$clog2(DEPTH)`: localparam, frame-buffer address width.

Ports (`clk`, `rst_n`):
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a dump; honoured only in IDLE.
- `subpage` in 1: subpage of this dump (status reg bit 0); sampled on accepted `start`.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: block accepts the word.
- `s_data` in WIDTH: sensor word, strictly in address order 0..DEPTH-1.
- `m_wr_en` out 1: frame-buffer write strobe.
- `m_wr_addr` out ADDRW: write address (= word index).
- `m_wr_data` out WIDTH: write data.
- `busy` out 1: high in FETCH and RUN.
- `done` out 1: one-cycle pulse at end of dump.
- `wr_count` out `$clog2(DEPTH+1)`: words written this dump; held after done.

## Operation
- FSM states: IDLE, FETCH, RUN, DONE.
- IDLE:
  - On `start`: latch `subpage` to `sp_q`, clear `idx` and `wr_count`, drive ROM address 0, go to FETCH.
  - `s_ready` = 0.
- FETCH: one cycle waiting on ROM latency; go to RUN. `s_ready` = 0.
- RUN:
  - `s_ready` = 1; accept = `s_valid && s_ready`.
  - ROM address is combinational: `accept ? idx+1 : idx`. The mask bit for `idx` is therefore valid in every RUN cycle, and throughput is one word per cycle with no bubbles.
  - `sel` = `sp_q ? data_pg1 : data_pg0`.
  - On accept, register `m_wr_addr <= idx` and `m_wr_data <= s_data`.
  - `m_wr_en <= sel || (idx >= 768)`. Aux words are always written, whatever the ROM content.
  - `wr_count` increments when the write is issued.
  - `idx` increments on accept.
  - Accepting `idx == DEPTH-1`: go to DONE; `s_ready` drops the next cycle.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- Ignored inputs:
  - `start` outside IDLE is ignored.
  - `subpage` changes after the latch have no effect.
  - `s_valid` outside RUN is ignored; no word is consumed.
- Mask content: pixel k = row*32+col. Subpage 0 mask is 1 where (row+col) is even; subpage 1 mask is its complement.
- Address 831 is the last word. `idx` never wraps; the next dump restarts from 0.

## Timing
- Reset values:
  - `s_ready`, `m_wr_en`, `busy`, `done` = 0.
  - `m_wr_addr`, `m_wr_data`, `wr_count` = 0.
  - FSM = IDLE, `sp_q` = 0.
- `start` sampled at edge N: `busy` high from N+1, `s_ready` high from N+2.
- Accept at edge M: `m_wr_en`, address and data valid in cycle M+1, for one cycle only.
- Last accept at edge L:
  - Final write and `done` are both high in cycle L+1.
  - `busy` = 0 and IDLE from L+2.
  - Earliest next `start` sample is at L+2.
- `rst_n` asserted mid-dump: all outputs clear immediately (asynchronously), with no partial write on release. The dump is abandoned and the upstream reader restarts it.
- ROM read latency is exactly 1 cycle.
- `wr_count` max is DEPTH, held in `$clog2(DEPTH+1)` bits.

## Structure
- Shared package `mlx90640_pkg` holds:
  - `MLX_COLS`=32, `MLX_ROWS`=24, `MLX_PIXELS`=768, `MLX_AUX`=64, `MLX_WORDS`=832.
  - FSM typedef `merge_state_t` {IDLE, FETCH, RUN, DONE}.
- Single sub-module: `mlx90640_subpages_rom_sync` (WIDTH=1, DEPTH=`MLX_WORDS`), instantiated once and read through both `data_pg0` and `data_pg1`.

## Test plan
- Reset: hold `rst_n` low with random inputs -> all outputs 0, `s_ready` 0, no `m_wr_en`.
- Subpage 0 dump: `start` with subpage=0, 832 back-to-back words with data=index.
  - Writes occur at addr 0,2,...,30, then 33,35,...,63, then 64,... and at every address 768..831.
  - Addr 1 and addr 32 are never written.
  - `wr_count` = 448; `done` high in the cycle of the write to 831.
- Subpage 1, same stream: addr 1 and 32 written, addr 0 not; `wr_count` = 448. The union of the subpage 0 and subpage 1 pixel addresses covers 0..767 exactly once.
- Random `s_valid` gaps (~50%):
  - Write sequence (addr, data) identical to the back-to-back case.
  - No write while `s_valid` is low.
  - `start` to first `s_ready` is exactly 2 cycles.
- Protocol abuse:
  - `start` pulsed mid-dump and `subpage` toggled at word 100 -> no effect on the write sequence.
  - `s_valid` high during IDLE/FETCH -> no accept, no write.
- Mid-dump reset: assert `rst_n` low at word 400 -> outputs 0 immediately. A fresh dump then completes with `wr_count` = 448.
